// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
// Opcodes, FSM state codes and datapath mux select values.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_ALU_WB   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_ERROR    = 4'd13
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // States that sit on the memory handshake
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter for the control sequencer.
// Flags expiry on the last tolerated cycle without mem_ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic waiting,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Clear on entry to a wait state, count cycles spent without ack
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_cnt <= '0;
        end else if (waiting) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && waiting && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer: state register, next-state,
// Moore output decode and retired-instruction counter.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_2_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             mem_error,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next;
    logic             w_start;
    logic             w_waiting;
    logic             w_expired;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

    assign w_waiting = is_wait_state(r_state) && !mem_ready;
    assign w_start   = is_wait_state(w_next) && (w_next != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .waiting(w_waiting),
        .expired(w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RESET;
        else     r_state <= w_next;
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_expired) w_next = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_expired) w_next = S_ERROR;
            end
            S_MEM_WB: w_next = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_expired) w_next = S_ERROR;
            end
            S_EXEC:    w_next = S_ALU_WB;
            S_ALU_WB:  w_next = S_FETCH;
            S_ADDI_EX: w_next = S_ADDI_WB;
            S_ADDI_WB: w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_RESET;
        endcase
    end

    // Datapath control decode; everything forced low while in reset
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_2_reg     = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        illegal_op    = 1'b0;
        mem_error     = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH;
                    illegal_op = !(opcode inside
                        {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW});
                end
                S_MEM_ADDR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write = 1'b1;
                    mem_2_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_ADDI_WB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCS_ALUOUT;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                end
                S_ERROR: mem_error = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_retire = !rst && ((r_state inside
        {S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP})
        || ((r_state == S_MEM_WR) && mem_ready));

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst)           r_count <= '0;
        else if (w_retire) r_count <= r_count + CNT_W'(1);
    end

    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed per-cycle
// state sequences, expectations queued, checked on the falling edge.
module tb_multicycle_ctrl_fsm;

    localparam int T_RST = 0, T_F = 1, T_D = 2, T_MA = 3, T_MRD = 4;
    localparam int T_MWB = 5, T_MWR = 6, T_EX = 7, T_AWB = 8;
    localparam int T_AX = 9, T_IWB = 10, T_BR = 11, T_JMP = 12;
    localparam int T_ERR = 13;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, ADDI = 6'h08;
    localparam logic [5:0] RT = 6'h00, BEQ = 6'h04, JMP = 6'h02;
    localparam logic [5:0] BAD = 6'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic        illegal_op, mem_error;
    logic [31:0] instr_count;

    typedef struct {
        logic [18:0] v;
        logic [31:0] c;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   step_id = 0;
    logic [31:0] exp_cnt = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_2_reg(mem_2_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal_op(illegal_op), .mem_error(mem_error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] sig(int st, bit rdy,
                                        logic [5:0] op, bit r);
        logic pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill, me;
        logic [1:0] sb, ao, ps;
        {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill, me} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        if (!r) begin
            case (st)
                T_F:   begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
                T_D:   begin
                    sb = 2'b11;
                    ill = !(op inside {LW, SW, ADDI, RT, BEQ, JMP});
                end
                T_MA, T_AX: begin sa = 1; sb = 2'b10; end
                T_MRD: begin mr = 1; iod = 1; end
                T_MWB: begin rw = 1; m2r = 1; end
                T_MWR: begin mw = 1; iod = 1; end
                T_EX:  begin sa = 1; ao = 2'b10; end
                T_AWB: begin rw = 1; rd = 1; end
                T_IWB: rw = 1;
                T_BR:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
                T_JMP: begin pcw = 1; ps = 2'b10; end
                T_ERR: me = 1;
                default: ;
            endcase
        end
        return {pcw, pcwc, iod, mr, mw, irw, m2r, rd, rw, sa,
                sb, ao, ps, ill, me};
    endfunction

    // One clock cycle: drive inputs, queue the expected response
    task automatic step(int st, bit rdy, logic [5:0] op, bit r);
        exp_t e;
        rst = r;
        mem_ready = rdy;
        opcode = op;
        e.v = sig(st, rdy, op, r);
        e.c = exp_cnt;
        e.id = step_id;
        q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
        if (r) exp_cnt = 0;
        else if (st inside {T_MWB, T_AWB, T_IWB, T_BR, T_JMP}
                 || (st == T_MWR && rdy)) exp_cnt++;
    endtask

    task automatic seq(int n, int st, bit rdy, logic [5:0] op);
        for (int i = 0; i < n; i++) step(st, rdy, op, 1'b0);
    endtask

    // Monitor: compare DUT outputs against queued expectations
    always @(negedge clk) begin
        exp_t e;
        logic [18:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                   ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source, illegal_op, mem_error};
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL ctrl step %0d: got %b expected %b",
                         e.id, act, e.v);
            end
            n_checks++;
            if (instr_count !== e.c) begin
                n_fail++;
                $display("FAIL count step %0d: got %0d expected %0d",
                         e.id, instr_count, e.c);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        seq(0, T_F, 1'b1, RT);
        for (int i = 0; i < 3; i++) step(T_RST, 1'b1, RT, 1'b1);
        step(T_RST, 1'b1, RT, 1'b0);
        // LW
        step(T_F, 1, LW, 0); step(T_D, 1, LW, 0); step(T_MA, 1, LW, 0);
        step(T_MRD, 1, LW, 0); step(T_MWB, 1, LW, 0);
        // SW
        step(T_F, 1, SW, 0); step(T_D, 1, SW, 0); step(T_MA, 1, SW, 0);
        step(T_MWR, 1, SW, 0);
        // ADDI
        step(T_F, 1, ADDI, 0); step(T_D, 1, ADDI, 0);
        step(T_AX, 1, ADDI, 0); step(T_IWB, 1, ADDI, 0);
        // R-type
        step(T_F, 1, RT, 0); step(T_D, 1, RT, 0);
        step(T_EX, 1, RT, 0); step(T_AWB, 1, RT, 0);
        // BEQ, J
        step(T_F, 1, BEQ, 0); step(T_D, 1, BEQ, 0); step(T_BR, 1, BEQ, 0);
        step(T_F, 1, JMP, 0); step(T_D, 1, JMP, 0); step(T_JMP, 1, JMP, 0);
        // LW with three wait cycles in MEM_RD
        step(T_F, 1, LW, 0); step(T_D, 1, LW, 0); step(T_MA, 1, LW, 0);
        seq(3, T_MRD, 1'b0, LW);
        step(T_MRD, 1, LW, 0); step(T_MWB, 1, LW, 0);
        // illegal opcode
        step(T_F, 1, BAD, 0); step(T_D, 1, BAD, 0);
        // ack arrives on the 16th wait cycle of FETCH
        seq(15, T_F, 1'b0, JMP);
        step(T_F, 1, JMP, 0); step(T_D, 1, JMP, 0); step(T_JMP, 1, JMP, 0);
        // reset while SW waits in MEM_WR
        step(T_F, 1, SW, 0); step(T_D, 1, SW, 0); step(T_MA, 1, SW, 0);
        step(T_MWR, 0, SW, 0);
        step(T_MWR, 0, SW, 1);
        step(T_RST, 0, SW, 0);
        // FETCH timeout into ERROR
        seq(16, T_F, 1'b0, RT);
        seq(3, T_ERR, 1'b0, RT);
        seq(2, T_ERR, 1'b1, LW);
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
